// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and defaults for the pixel memory controller
package mem_ctrl_pkg;

  localparam int MAX_ROW_DEF = 540;
  localparam int MAX_COL_DEF = 540;
  localparam int ADDR_W_DEF  = 19;
  localparam int DATA_W_DEF  = 8;
  localparam int LEN_W       = 20;
  localparam int ROW_W       = 10;
  localparam int MODE1_LEN   = 291600;
  localparam int MODE2_LEN   = 1620;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    MODE_1 = 1'b0,
    MODE_2 = 1'b1
  } mode_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - control, BRAM read and pixel stream signals of mem_ctrl
interface mem_ctrl_if import mem_ctrl_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              is_mode1_i;
  logic              mode1_run_i;
  logic              is_mode2_i;
  logic              fetch_run_i;
  logic [LEN_W-1:0]  cnt_len_i;
  logic              mode1_done_o;
  logic              fetch_done_o;
  logic [ROW_W-1:0]  cnt_img_row_o;
  logic              bram_en_o;
  logic [ADDR_W-1:0] bram_addr_o;
  logic [DATA_W-1:0] bram_rdata_i;
  logic              pix_valid_o;
  logic [DATA_W-1:0] pix_data_o;
  logic              pix_last_o;
  logic              pix_ready_i;
  logic              busy_o;
  logic [1:0]        state_o;

  modport master (
    input  is_mode1_i, mode1_run_i, is_mode2_i, fetch_run_i, cnt_len_i,
    input  bram_rdata_i, pix_ready_i,
    output mode1_done_o, fetch_done_o, cnt_img_row_o, bram_en_o, bram_addr_o,
    output pix_valid_o, pix_data_o, pix_last_o, busy_o, state_o
  );

  modport slave (
    output is_mode1_i, mode1_run_i, is_mode2_i, fetch_run_i, cnt_len_i,
    output bram_rdata_i, pix_ready_i,
    input  mode1_done_o, fetch_done_o, cnt_img_row_o, bram_en_o, bram_addr_o,
    input  pix_valid_o, pix_data_o, pix_last_o, busy_o, state_o
  );

endinterface

// File: rtl/pix_skid_buf.sv
// rtl/pix_skid_buf.sv - two-entry pixel buffer with valid/ready on both sides and flush
module pix_skid_buf import mem_ctrl_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_tvalid,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic              m_tvalid,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [1:0]        level
);

  logic [DATA_W-1:0] data_q [2];
  logic [1:0]        last_q;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              push;
  logic              pop;

  assign s_tready = (count_q != 2'd2);
  assign m_tvalid = (count_q != 2'd0);
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;
  assign level    = count_q;

  // Output is forced to zero when empty so stale pixels never show on the bus
  assign m_tdata  = m_tvalid ? data_q[rd_ptr_q] : '0;
  assign m_tlast  = m_tvalid & last_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else if (flush) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= s_tdata;
        last_q[wr_ptr_q] <= s_tlast;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - BRAM-to-pixel-stream controller for full-image and row-window fetches
module mem_ctrl import mem_ctrl_pkg::*; #(
  parameter int MAX_ROW = MAX_ROW_DEF,
  parameter int MAX_COL = MAX_COL_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.master bus
);

  localparam logic [ROW_W-1:0]  ROW_SAT  = ROW_W'(MAX_ROW - 3);
  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(MAX_COL);

  state_t            state_q, state_d;
  mode_t             mode_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issue_cnt_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] base_reg_q;
  logic [ROW_W-1:0]  row_q;
  logic              first_q;
  logic              run1_q;
  logic              run2_q;
  logic              rd_pend_q;
  logic              rd_last_q;
  logic              mode1_done_q;
  logic              fetch_done_q;

  logic              start1;
  logic              start2;
  logic              start_m1;
  logic              start_m2;
  logic              active_run;
  logic              abort;
  logic              pix_pop;
  logic [2:0]        occ;
  logic              credit;
  logic              issue;
  logic              issue_last;
  logic              last_pop;
  logic [1:0]        skid_level;
  logic              skid_ready;

  assign start1     = bus.mode1_run_i & ~run1_q;
  assign start2     = bus.fetch_run_i & ~run2_q;
  assign start_m1   = (state_q == S_IDLE) && start1;
  assign start_m2   = (state_q == S_IDLE) && start2 && !start1;
  assign active_run = (mode_q == MODE_1) ? bus.mode1_run_i : bus.fetch_run_i;
  assign abort      = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !active_run;

  // Slots committed after this cycle: buffered + in flight, minus the one leaving now
  assign pix_pop    = bus.pix_valid_o & bus.pix_ready_i;
  assign occ        = {1'b0, skid_level} + {2'b0, rd_pend_q} - {2'b0, pix_pop};
  assign credit     = (occ < 3'd2);
  assign issue      = (state_q == S_RUN) && !abort && (issue_cnt_q != len_q) && credit;
  assign issue_last = issue && (issue_cnt_q == len_q - LEN_W'(1));
  assign last_pop   = pix_pop & bus.pix_last_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_m1 || start_m2) state_d = S_RUN;
      end
      S_RUN: begin
        if (abort)                   state_d = S_IDLE;
        else if (len_q == '0)        state_d = S_DONE;
        else if (issue_last)         state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)                   state_d = S_IDLE;
        else if (last_pop)           state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= MODE_1;
      len_q        <= '0;
      issue_cnt_q  <= '0;
      base_q       <= '0;
      base_reg_q   <= '0;
      row_q        <= '0;
      first_q      <= 1'b1;
      run1_q       <= 1'b0;
      run2_q       <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      mode1_done_q <= 1'b0;
      fetch_done_q <= 1'b0;
    end else begin
      run1_q <= bus.mode1_run_i;
      run2_q <= bus.fetch_run_i;

      if (!bus.is_mode2_i)  first_q <= 1'b1;
      else if (start_m2)    first_q <= 1'b0;

      if (start_m1) begin
        mode_q      <= MODE_1;
        len_q       <= bus.cnt_len_i;
        issue_cnt_q <= '0;
        base_q      <= '0;
      end else if (start_m2) begin
        mode_q      <= MODE_2;
        len_q       <= bus.cnt_len_i;
        issue_cnt_q <= '0;
        // Window base advances by one row per fetch using an adder, saturating at the last window
        if (first_q) begin
          row_q      <= '0;
          base_reg_q <= '0;
          base_q     <= '0;
        end else if (row_q < ROW_SAT) begin
          row_q      <= row_q + ROW_W'(1);
          base_reg_q <= base_reg_q + COL_STEP;
          base_q     <= base_reg_q + COL_STEP;
        end else begin
          base_q     <= base_reg_q;
        end
      end else if (issue) begin
        issue_cnt_q <= issue_cnt_q + LEN_W'(1);
      end

      rd_pend_q    <= issue;
      rd_last_q    <= issue_last;
      mode1_done_q <= (state_q == S_DONE) && (mode_q == MODE_1);
      fetch_done_q <= (state_q == S_DONE) && (mode_q == MODE_2);
    end
  end

  pix_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort),
    .s_tvalid (rd_pend_q & skid_ready),
    .s_tdata  (bus.bram_rdata_i),
    .s_tlast  (rd_last_q),
    .s_tready (skid_ready),
    .m_tvalid (bus.pix_valid_o),
    .m_tdata  (bus.pix_data_o),
    .m_tlast  (bus.pix_last_o),
    .m_tready (bus.pix_ready_i),
    .level    (skid_level)
  );

  assign bus.bram_en_o     = issue;
  assign bus.bram_addr_o   = base_q + ADDR_W'(issue_cnt_q);
  assign bus.busy_o        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.state_o       = state_q;
  assign bus.cnt_img_row_o = row_q;
  assign bus.mode1_done_o  = mode1_done_q;
  assign bus.fetch_done_o  = fetch_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_if bus ();
  mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  int cyc = 0, pix_total = 0, en_total = 0, last_total = 0;
  int done1_total = 0, done2_total = 0, bad_pix = 0, bad_addr = 0;
  int first_cyc = 0, last_cyc = 0;
  int pix_base = 0, en_base = 0, exp_len = 0;
  logic [18:0] exp_base = '0;
  int d1_snap, d2_snap, en_snap, pix_snap;

  function automatic logic [7:0] bram_f(input logic [18:0] a);
    return 8'(a * 19'd3 + (a >> 9) + 19'd5);
  endfunction

  always @(posedge clk) begin
    if (bus.bram_en_o) bus.bram_rdata_i <= bram_f(bus.bram_addr_o);
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.bram_en_o) begin
      if (bus.bram_addr_o !== exp_base + 19'(en_total - en_base)) bad_addr <= bad_addr + 1;
      en_total <= en_total + 1;
    end
    if (bus.pix_valid_o && bus.pix_ready_i) begin
      if (bus.pix_data_o !== bram_f(exp_base + 19'(pix_total - pix_base)) ||
          bus.pix_last_o !== ((pix_total - pix_base) == exp_len - 1))
        bad_pix <= bad_pix + 1;
      if (pix_total == pix_base) first_cyc <= cyc;
      if (bus.pix_last_o) begin
        last_cyc   <= cyc;
        last_total <= last_total + 1;
      end
      pix_total <= pix_total + 1;
    end
    if (bus.mode1_done_o) done1_total <= done1_total + 1;
    if (bus.fetch_done_o) done2_total <= done2_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_job(input bit m1, input int len, input int base);
    pix_base      = pix_total;
    en_base       = en_total;
    exp_base      = 19'(base);
    exp_len       = len;
    bus.cnt_len_i = 20'(len);
    if (m1) bus.mode1_run_i = 1'b1;
    else    bus.fetch_run_i = 1'b1;
  endtask

  task automatic wait_done(input bit m1, input int budget, input bit rnd, input string tag);
    int  d0;
    bit  got;
    d0  = m1 ? done1_total : done2_total;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      cyc1();
      if (rnd) bus.pix_ready_i = 1'($urandom_range(0, 1));
      got = ((m1 ? done1_total : done2_total) != d0);
    end
    bus.pix_ready_i = 1'b1;
    chk(tag, 32'(got), 32'd1);
  endtask

  task automatic short_fetch(input int len, input int base, input int row, input string tag);
    cyc1();
    begin_job(1'b0, len, base);
    wait_done(1'b0, 500, 1'b0, tag);
    bus.fetch_run_i = 1'b0;
    cyc1();
    chk({tag, "_row"}, 32'(bus.cnt_img_row_o), 32'(row));
    chk({tag, "_npix"}, 32'(pix_total - pix_base), 32'(len));
  endtask

  initial begin
    rst = 1'b1;
    bus.is_mode1_i  = 1'b0;
    bus.mode1_run_i = 1'b0;
    bus.is_mode2_i  = 1'b0;
    bus.fetch_run_i = 1'b0;
    bus.cnt_len_i   = '0;
    bus.pix_ready_i = 1'b1;
    repeat (3) cyc1();
    chk("rst_ctrl", {26'd0, bus.mode1_done_o, bus.fetch_done_o, bus.bram_en_o,
                     bus.pix_valid_o, bus.pix_last_o, bus.busy_o}, 32'd0);
    chk("rst_state", 32'(bus.state_o), 32'd0);
    chk("rst_data", 32'(bus.pix_data_o), 32'd0);
    chk("rst_addr", 32'(bus.bram_addr_o), 32'd0);
    chk("rst_row", 32'(bus.cnt_img_row_o), 32'd0);
    rst = 1'b0;
    bus.is_mode2_i = 1'b1;
    cyc1();

    // first window fetch: latency, ordering, throughput
    begin_job(1'b0, MODE2_LEN, 0);
    cyc1();
    chk("a_state_run", 32'(bus.state_o), 32'd1);
    chk("a_busy", 32'(bus.busy_o), 32'd1);
    cyc1();
    chk("a_valid_e1", 32'(bus.pix_valid_o), 32'd0);
    cyc1();
    chk("a_valid_e2", 32'(bus.pix_valid_o), 32'd1);
    chk("a_first_data", 32'(bus.pix_data_o), 32'd5);
    d1_snap = done1_total;
    wait_done(1'b0, 5000, 1'b0, "a_done");
    repeat (3) cyc1();
    chk("a_no_restart", 32'(bus.state_o), 32'd0);
    chk("a_npix", 32'(pix_total - pix_base), 32'd1620);
    chk("a_nreads", 32'(en_total - en_base), 32'd1620);
    chk("a_rate", 32'(last_cyc - first_cyc), 32'd1619);
    chk("a_last_cnt", 32'(last_total), 32'd1);
    chk("a_bad_pix", 32'(bad_pix), 32'd0);
    chk("a_bad_addr", 32'(bad_addr), 32'd0);
    chk("a_done_once", 32'(done2_total), 32'd1);
    chk("a_no_m1done", 32'(done1_total - d1_snap), 32'd0);
    chk("a_row", 32'(bus.cnt_img_row_o), 32'd0);
    bus.fetch_run_i = 1'b0;

    short_fetch(20, 540, 1, "b");
    short_fetch(20, 1080, 2, "c");
    chk("bc_bad_pix", 32'(bad_pix), 32'd0);
    chk("bc_bad_addr", 32'(bad_addr), 32'd0);

    // abort after 100 accepted pixels
    cyc1();
    begin_job(1'b0, MODE2_LEN, 1620);
    d2_snap = done2_total;
    for (int i = 0; i < 500 && (pix_total - pix_base) < 100; i++) cyc1();
    chk("d_reached_100", 32'((pix_total - pix_base) >= 100), 32'd1);
    bus.fetch_run_i = 1'b0;
    cyc1();
    chk("d_idle", 32'(bus.state_o), 32'd0);
    chk("d_valid", 32'(bus.pix_valid_o), 32'd0);
    chk("d_busy", 32'(bus.busy_o), 32'd0);
    en_snap = en_total;
    repeat (5) cyc1();
    chk("d_no_done", 32'(done2_total - d2_snap), 32'd0);
    chk("d_row", 32'(bus.cnt_img_row_o), 32'd3);
    chk("d_no_reads", 32'(en_total - en_snap), 32'd0);
    chk("d_bad_pix", 32'(bad_pix), 32'd0);

    // full-image stream with random backpressure
    bus.is_mode2_i = 1'b0;
    bus.is_mode1_i = 1'b1;
    cyc1();
    d2_snap = done2_total;
    d1_snap = done1_total;
    begin_job(1'b1, 3000, 0);
    wait_done(1'b1, 20000, 1'b1, "e_done");
    repeat (3) cyc1();
    chk("e_npix", 32'(pix_total - pix_base), 32'd3000);
    chk("e_bad_pix", 32'(bad_pix), 32'd0);
    chk("e_bad_addr", 32'(bad_addr), 32'd0);
    chk("e_done_once", 32'(done1_total - d1_snap), 32'd1);
    chk("e_no_fdone", 32'(done2_total - d2_snap), 32'd0);
    chk("e_row_hold", 32'(bus.cnt_img_row_o), 32'd3);
    bus.mode1_run_i = 1'b0;
    cyc1();

    // reset in the middle of a job
    d1_snap = done1_total;
    begin_job(1'b1, 3000, 0);
    repeat (50) cyc1();
    rst = 1'b1;
    bus.mode1_run_i = 1'b0;
    cyc1();
    chk("f_ctrl", {26'd0, bus.mode1_done_o, bus.fetch_done_o, bus.bram_en_o,
                   bus.pix_valid_o, bus.pix_last_o, bus.busy_o}, 32'd0);
    chk("f_state", 32'(bus.state_o), 32'd0);
    chk("f_data", 32'(bus.pix_data_o), 32'd0);
    chk("f_row", 32'(bus.cnt_img_row_o), 32'd0);
    cyc1();
    rst = 1'b0;
    bus.is_mode1_i = 1'b0;
    bus.is_mode2_i = 1'b1;
    repeat (3) cyc1();
    chk("f_no_done", 32'(done1_total - d1_snap), 32'd0);

    // zero-length fetch
    begin_job(1'b0, 0, 0);
    cyc1();
    chk("g_state_run", 32'(bus.state_o), 32'd1);
    chk("g_done_e0", 32'(bus.fetch_done_o), 32'd0);
    cyc1();
    chk("g_state_done", 32'(bus.state_o), 32'd3);
    chk("g_done_e1", 32'(bus.fetch_done_o), 32'd0);
    cyc1();
    chk("g_done_e2", 32'(bus.fetch_done_o), 32'd1);
    cyc1();
    chk("g_done_e3", 32'(bus.fetch_done_o), 32'd0);
    chk("g_no_reads", 32'(en_total - en_base), 32'd0);
    chk("g_no_pix", 32'(pix_total - pix_base), 32'd0);
    chk("g_row", 32'(bus.cnt_img_row_o), 32'd0);
    bus.fetch_run_i = 1'b0;

    // walk the window down to saturation
    for (int i = 0; i < 537; i++) begin
      cyc1();
      begin_job(1'b0, 0, 0);
      repeat (4) cyc1();
      bus.fetch_run_i = 1'b0;
    end
    cyc1();
    chk("h_row_537", 32'(bus.cnt_img_row_o), 32'd537);
    short_fetch(4, 537 * 540, 537, "h_sat");
    chk("h_bad_addr", 32'(bad_addr), 32'd0);
    chk("h_bad_pix", 32'(bad_pix), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters SHALL be: MAX_ROW, default 540, image rows; MAX_COL, default 540, pixels per row; ADDR_W, default 19, BRAM address width; DATA_W, default 8, pixel width.
REQ-002 Ports SHALL be, in order:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- is_mode1_i  in  1  controller in a mode-1 state.
- mode1_run_i  in  1  mode-1 full-image stream request (level).
- is_mode2_i  in  1  controller in a mode-2 state.
- fetch_run_i  in  1  mode-2 window fetch request (level).
- cnt_len_i  in  20  pixels to transfer; sampled at job start.
- mode1_done_o  out  1  one-cycle pulse: mode-1 job complete.
- fetch_done_o  out  1  one-cycle pulse: mode-2 fetch complete.
- cnt_img_row_o  out  10  top row of the current mode-2 window.
- bram_en_o  out  1  BRAM read enable.
- bram_addr_o  out  ADDR_W  BRAM read address.
- bram_rdata_i  in  DATA_W  BRAM data; valid 1 cycle after bram_en_o.
- pix_valid_o  out  1  output pixel valid.
- pix_data_o  out  DATA_W  output pixel.
- pix_last_o  out  1  marks final pixel of a job.
- pix_ready_i  in  1  downstream accepts a pixel when valid and ready are both high.
- busy_o  out  1  job in progress.
- state_o  out  2  FSM state, debug only.

Function
REQ-003 Job start SHALL be the rising edge of a run input (high now, low the previous cycle). If both rise in the same cycle, mode1_run_i wins. A run held high after done SHALL NOT restart a job.
REQ-004 FSM SHALL have four states:
- S_IDLE=0: on start, go to S_RUN.
- S_RUN=1: issue reads; after the last read is issued, go to S_DRAIN.
- S_DRAIN=2: after the last pixel is accepted, go to S_DONE.
- S_DONE=3: assert the done pulse for exactly one cycle, then go to S_IDLE.
REQ-005 At start the block SHALL latch cnt_len_i and the mode. Base address SHALL be 0 for mode 1 and base_reg for mode 2.
REQ-006 Address SHALL be base + issue count, 1 per issued read. The issue count SHALL stop at the latched length.
REQ-007 Reads SHALL be issued only if the 2-entry skid buffer, counting in-flight reads, has a free slot. No pixel SHALL be lost or duplicated under any pix_ready_i pattern.
REQ-008 Throughput SHALL be 1 pixel/cycle while pix_ready_i stays high. First pix_valid_o SHALL assert exactly 2 cycles after the start edge.
REQ-009 Pixels SHALL be output in strictly increasing address order. pix_last_o SHALL be high only on pixel number (length-1).
REQ-010 A latched length of 0 SHALL go from S_RUN directly to S_DONE, with no BRAM reads and no pixels.
REQ-011 Row tracking:
- A first-fetch flag SHALL be set while is_mode2_i is low.
- On a mode-2 start with the flag set: row=0, base_reg=0, flag cleared.
- On any later mode-2 start: row+1, base_reg+MAX_COL.
- Row and base_reg SHALL saturate at MAX_ROW-3 and (MAX_ROW-3)*MAX_COL.
- No multiplier SHALL be used.
REQ-012 cnt_img_row_o SHALL be registered and SHALL hold its value between fetches and during mode 1.
REQ-013 If the active run input drops before S_DONE (abort), the block SHALL return to S_IDLE next cycle and flush the skid buffer. It SHALL assert no done pulse and SHALL leave row unchanged.
REQ-014 fetch_done_o SHALL pulse only for mode-2 jobs and mode1_done_o only for mode-1 jobs. busy_o SHALL be high in S_RUN and S_DRAIN.

Reset
REQ-015 rst SHALL force, on the next edge:
- state S_IDLE
- all counters 0, row 0, base_reg 0
- first-fetch flag set, skid buffer empty
- all outputs 0 (pix_data_o 0)
Reset asserted mid-job SHALL drop the job with no done pulse.

Structure
REQ-016 A shared package SHALL hold the state enum, MAX_ROW/MAX_COL defaults, ADDR_W/DATA_W, and the mode-1 length 291600 and mode-2 length 1620. The controller SHALL use the same package.
REQ-017 The skid buffer SHALL be a sub-module named pix_skid_buf (2 entries, valid/ready both sides). The FSM and counters SHALL stay in mem_ctrl.

Verification
REQ-018 Mode-2 start, cnt_len_i=1620, pix_ready_i=1 -> addresses 0..1619 in order; 1620 pixels; pix_last_o on the 1620th; one fetch_done_o pulse; cnt_img_row_o=0.
REQ-019 Second and third mode-2 starts -> base addresses 540 and 1080; cnt_img_row_o=1 then 2. After 537 increments, a further start keeps row 537.
REQ-020 Mode-1 start, cnt_len_i=291600, pix_ready_i random 50% -> data equals BRAM model at addresses 0..291599 with no loss or duplication; one mode1_done_o pulse.
REQ-021 fetch_run_i dropped after 100 accepted pixels -> S_IDLE next cycle; no fetch_done_o; pix_valid_o=0; row unchanged.
REQ-022 rst=1 mid-job, then cnt_len_i=0 start -> all outputs 0 after reset; zero-length job gives no bram_en_o and one done pulse 2 cycles after the start edge.
